// File: rtl/sha2_round_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sha2_round_ctrl_pkg
//  Description : Shared constants and state encodings for the SHA-256
//                compression-pass sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package sha2_round_ctrl_pkg;

    // Compression rounds per block, directly loaded message words, and the
    // round-counter width (2**CW must cover ROUNDS).
    localparam int ROUNDS = 64;
    localparam int WORDS  = 16;
    localparam int CW     = 6;

    // Sequencer state encodings.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_ROUND  = 3'd3;
    localparam logic [2:0] ST_UPDATE = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    // Round indices that trigger the LOAD->ROUND and ROUND->UPDATE exits.
    localparam logic [CW-1:0] LAST_WORD  = CW'(WORDS - 1);
    localparam logic [CW-1:0] LAST_ROUND = CW'(ROUNDS - 1);

endpackage
`default_nettype wire

// File: rtl/sha2_round_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sha2_round_ctrl_if
//  Description : Handshake and enable bundle between the IPU top / message
//                source (master) and the round sequencer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface sha2_round_ctrl_if;

    logic                             start;
    logic                             abort;
    logic                             w_vld;
    logic                             w_rdy;
    logic                             ld_w;
    logic                             init_hv;
    logic                             rnd_en;
    logic                             sched_en;
    logic                             upd_hv;
    logic [sha2_round_ctrl_pkg::CW-1:0] rnd_idx;
    logic                             busy;
    logic                             done;

    modport master (
        output start, abort, w_vld,
        input  w_rdy, ld_w, init_hv, rnd_en, sched_en, upd_hv, rnd_idx, busy, done
    );

    modport slave (
        input  start, abort, w_vld,
        output w_rdy, ld_w, init_hv, rnd_en, sched_en, upd_hv, rnd_idx, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/sha2_round_ctrl_cntr.sv
`default_nettype none
// ============================================================================
//  Module      : cntr
//  Description : Round counter with synchronous clear (priority) and count
//                enable; asynchronous active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module cntr #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         clr,
    input  logic         c_up,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next count: clear wins over increment.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (c_up) begin
            q_d = q_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/sha2_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sha2_round_ctrl
//  Description : Sequencer for one SHA-256 compression pass. Loads 16
//                message words, runs 64 rounds, updates the hash state and
//                pulses done. Moore outputs except ld_w/rnd_en in LOAD.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha2_round_ctrl
    import sha2_round_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_b,
    sha2_round_ctrl_if.slave bus
);

    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic [CW-1:0] w_idx;
    logic          w_clr;
    logic          w_rdy;
    logic          w_ld;
    logic          w_init;
    logic          w_rnd;
    logic          w_sched;
    logic          w_upd;
    logic          w_done;

    // Next-state, counter control and output decode; abort overrides all.
    always_comb begin
        state_d = state_q;
        w_clr   = 1'b0;
        w_rdy   = 1'b0;
        w_ld    = 1'b0;
        w_init  = 1'b0;
        w_rnd   = 1'b0;
        w_sched = 1'b0;
        w_upd   = 1'b0;
        w_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    w_clr   = 1'b1;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                w_init  = 1'b1;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                w_rdy = 1'b1;
                if (bus.w_vld) begin
                    w_ld  = 1'b1;
                    w_rnd = 1'b1;
                    if (w_idx == LAST_WORD) begin
                        state_d = ST_ROUND;
                    end
                end
            end
            ST_ROUND: begin
                w_rnd   = 1'b1;
                w_sched = 1'b1;
                if (w_idx == LAST_ROUND) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                w_upd   = 1'b1;
                w_clr   = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                w_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (bus.abort) begin
            state_d = ST_IDLE;
            w_clr   = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    cntr #(
        .W (CW)
    ) u_cntr (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (w_clr),
        .c_up  (w_rnd),
        .q     (w_idx)
    );

    assign bus.w_rdy    = w_rdy;
    assign bus.ld_w     = w_ld;
    assign bus.init_hv  = w_init;
    assign bus.rnd_en   = w_rnd;
    assign bus.sched_en = w_sched;
    assign bus.upd_hv   = w_upd;
    assign bus.rnd_idx  = w_idx;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = w_done;

endmodule
`default_nettype wire

// File: tb/tb_sha2_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha2_round_ctrl
//  Description : Self-checking bench for the SHA-256 round sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sha2_round_ctrl;

    logic clk;
    logic rst_b;

    sha2_round_ctrl_if bus ();

    sha2_round_ctrl dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int g_cyc  = 0;

    // Reference model: a phase of the block plus the round number t.
    localparam int P_IDLE = 0, P_INIT = 1, P_LOAD = 2, P_ROUND = 3, P_UPD = 4, P_DONE = 5;
    int m_phase = P_IDLE;
    int m_t     = 0;

    bit last_done, last_upd, last_ld;

    // Flags {busy,init_hv,w_rdy,ld_w,rnd_en,sched_en,upd_hv,done} then rnd_idx.
    function automatic logic [13:0] model_out(input bit v);
        logic [7:0] f;
        logic [5:0] idx;
        f = 8'h00;
        idx = 6'(m_t % 64);
        if (m_phase != P_IDLE) f[7] = 1'b1;
        if (m_phase == P_INIT) f[6] = 1'b1;
        if (m_phase == P_LOAD) begin
            f[5] = 1'b1;
            f[4] = v;
            f[3] = v;
        end
        if (m_phase == P_ROUND) begin
            f[3] = 1'b1;
            f[2] = 1'b1;
        end
        if (m_phase == P_UPD)  f[1] = 1'b1;
        if (m_phase == P_DONE) f[0] = 1'b1;
        return {f, idx};
    endfunction

    task automatic model_step(input bit s, input bit a, input bit v);
        if (a) begin
            m_phase = P_IDLE;
            m_t     = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (s) begin m_phase = P_INIT; m_t = 0; end
                P_INIT: m_phase = P_LOAD;
                P_LOAD: if (v) begin
                    if (m_t == 15) m_phase = P_ROUND;
                    m_t = m_t + 1;
                end
                P_ROUND: begin
                    if (m_t == 63) m_phase = P_UPD;
                    m_t = m_t + 1;
                end
                P_UPD: begin m_phase = P_DONE; m_t = 0; end
                default: m_phase = P_IDLE;
            endcase
        end
    endtask

    function automatic logic [13:0] dut_out();
        return {bus.busy, bus.init_hv, bus.w_rdy, bus.ld_w, bus.rnd_en,
                bus.sched_en, bus.upd_hv, bus.done, bus.rnd_idx};
    endfunction

    task automatic chk_vec(input string name, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: flags/idx got %b/%0d expected %b/%0d",
                     name, g_cyc, got[13:6], got[5:0], exp[13:6], exp[5:0]);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance.
    task automatic cyc(input bit s, input bit a, input bit v);
        bus.start = s;
        bus.abort = a;
        bus.w_vld = v;
        #1;
        chk_vec("model", dut_out(), model_out(v));
        last_done = bus.done;
        last_upd  = bus.upd_hv;
        last_ld   = bus.ld_w;
        model_step(s, a, v);
        g_cyc++;
        @(posedge clk);
        #1;
    endtask

    // One block started from IDLE; returns timing and event counts.
    task automatic run_block(input int stall_n, input int abort_idx, input bit poke,
                             output int done_k, output int done_abs, output int n_done,
                             output int n_upd, output int n_ld, output int n_sched);
        int stalled;
        bit s, a, v, fin;
        stalled = 0; fin = 1'b0;
        done_k = -1; done_abs = -1;
        n_done = 0; n_upd = 0; n_ld = 0; n_sched = 0;
        cyc(1'b1, 1'b0, 1'b1);
        if (last_ld) n_ld++;
        for (int k = 1; k < 200 && !fin; k++) begin
            if (!bus.busy) begin
                fin = 1'b1;
            end else begin
                s = 1'b0; a = 1'b0; v = 1'b1;
                if (bus.w_rdy && bus.rnd_idx == 6'd5 && stalled < stall_n) begin
                    v = 1'b0;
                    stalled++;
                end
                if (bus.sched_en && int'(bus.rnd_idx) == abort_idx) a = 1'b1;
                if (poke && (bus.sched_en || bus.done)) s = 1'b1;
                if (bus.sched_en) n_sched++;
                cyc(s, a, v);
                if (last_done) begin
                    n_done++;
                    if (done_k < 0) begin
                        done_k   = k;
                        done_abs = g_cyc - 1;
                    end
                end
                if (last_upd) n_upd++;
                if (last_ld)  n_ld++;
            end
        end
        if (!fin) chk_int("block_timeout", 0, 1);
    endtask

    typedef struct {
        bit          s;
        bit          a;
        bit          v;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int dk, da, nd, nu, nl, ns, da1;
        bit rs, ra, rv;

        tbl[0] = '{1'b0, 1'b0, 1'b0, {8'b0000_0000, 6'd0}};
        tbl[1] = '{1'b1, 1'b1, 1'b0, {8'b0000_0000, 6'd0}};
        tbl[2] = '{1'b0, 1'b0, 1'b0, {8'b0000_0000, 6'd0}};
        tbl[3] = '{1'b1, 1'b0, 1'b0, {8'b0000_0000, 6'd0}};
        tbl[4] = '{1'b0, 1'b0, 1'b0, {8'b1100_0000, 6'd0}};
        tbl[5] = '{1'b0, 1'b0, 1'b0, {8'b1010_0000, 6'd0}};
        tbl[6] = '{1'b0, 1'b0, 1'b1, {8'b1011_1000, 6'd0}};
        tbl[7] = '{1'b0, 1'b0, 1'b1, {8'b1011_1000, 6'd1}};
        tbl[8] = '{1'b0, 1'b1, 1'b0, {8'b1010_0000, 6'd2}};
        tbl[9] = '{1'b0, 1'b0, 1'b0, {8'b0000_0000, 6'd0}};

        // Reset asserted mid-cycle for 25 time units, start held high.
        rst_b = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.w_vld = 1'b0;
        #3  rst_b = 1'b0;
        #17 chk_vec("reset_hold", dut_out(), 14'd0);
        bus.start = 1'b1;
        #8  rst_b = 1'b1;
        #1  chk_vec("reset_release", dut_out(), 14'd0);
        @(posedge clk);
        #1;
        chk_vec("first_edge_init", dut_out(), {8'b1100_0000, 6'd0});
        m_phase = P_INIT;
        m_t     = 0;
        cyc(1'b0, 1'b1, 1'b0);

        // Table-driven short sequence from IDLE.
        for (int i = 0; i < 10; i++) begin
            bus.start = tbl[i].s;
            bus.abort = tbl[i].a;
            bus.w_vld = tbl[i].v;
            #1;
            chk_vec($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
            model_step(tbl[i].s, tbl[i].a, tbl[i].v);
            g_cyc++;
            @(posedge clk);
            #1;
        end

        // Nominal block.
        run_block(0, -1, 1'b0, dk, da, nd, nu, nl, ns);
        chk_int("nom_done_cycle", dk, 67);
        chk_int("nom_done_count", nd, 1);
        chk_int("nom_upd_count", nu, 1);
        chk_int("nom_ld_count", nl, 16);
        chk_int("nom_sched_count", ns, 48);
        chk_int("nom_idle_idx", int'(bus.rnd_idx), 0);

        // Stalled load: three w_vld=0 cycles at index 5.
        run_block(3, -1, 1'b0, dk, da, nd, nu, nl, ns);
        chk_int("stall_done_cycle", dk, 70);
        chk_int("stall_ld_count", nl, 16);

        // Abort at round 40.
        run_block(0, 40, 1'b0, dk, da, nd, nu, nl, ns);
        chk_int("abort_done_count", nd, 0);
        chk_int("abort_upd_count", nu, 0);
        chk_int("abort_idx", int'(bus.rnd_idx), 0);

        // start during ROUND and DONE ignored, then a fresh block.
        run_block(0, -1, 1'b1, dk, da, nd, nu, nl, ns);
        chk_int("poke_done_count", nd, 1);
        chk_int("poke_done_cycle", dk, 67);
        chk_int("poke_idle_after", int'(bus.busy), 0);
        run_block(0, -1, 1'b0, dk, da, nd, nu, nl, ns);
        chk_int("after_poke_done_cycle", dk, 67);

        // Back-to-back blocks.
        run_block(0, -1, 1'b0, dk, da1, nd, nu, nl, ns);
        run_block(0, -1, 1'b0, dk, da, nd, nu, nl, ns);
        chk_int("b2b_gap", da - da1, 68);

        // Randomized stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom % 8) == 0;
            ra = ($urandom % 64) == 0;
            rv = ($urandom % 4) != 0;
            cyc(rs, ra, rv);
        end

        // Asynchronous reset in the middle of a block.
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) cyc(1'b0, 1'b0, 1'b1);
        rst_b = 1'b0;
        #2 chk_vec("async_reset", dut_out(), 14'd0);
        m_phase = P_IDLE;
        m_t     = 0;
        #3 rst_b = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
